alu_seq: RTL and testbench

//  Parametrised, registered ALU with a valid/ready handshake on input and output. Same 3-bit opcode map
//  and C/Z flags as the 8-bit combinational ALU, plus N and V flags. Adds an iterative shift-add multiplier.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_seq_mul.sv | 54 +++++
 rtl/alu_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcode map, FSM states and the
// signed-overflow helper used by the ADD/SUB flag logic.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_NAND = 3'b101,
    OP_NOR  = 3'b110,
    OP_XOR  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Two's-complement overflow of a + b; for a - b pass the inverted b sign.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps.
// o_product is the accumulator value that the final step produces; valid while o_done.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;

  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign o_product = w_acc_nxt;
  assign o_done    = r_busy & (r_cnt == LAST_CNT);

  // Operand latch on start, then one shift-add step per cycle while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      r_busy   <= ~o_done;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, one operation in flight.
// Define ALU_MUL_EN to build the iterative multiplier; without it MUL returns 0 with op_err.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         opcode,
  input  logic [WIDTH-1:0]   operand1,
  input  logic [WIDTH-1:0]   operand2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               flag_c,
  output logic               flag_z,
  output logic               flag_n,
  output logic               flag_v,
  output logic               op_err
);

  state_e             r_state;
  state_e             w_state_nxt;
  opcode_e            w_op;
  logic               w_accept;
  logic               w_mul_path;
  logic               w_mul_done;
  logic               w_load;
  logic [2*WIDTH-1:0] w_product;
  logic [2*WIDTH-1:0] w_res_nxt;
  logic [WIDTH:0]     w_sum;
  logic               w_c_nxt;
  logic               w_v_nxt;
  logic               w_n_nxt;
  logic               w_err_nxt;

  logic [2*WIDTH-1:0] r_result;
  logic               r_c;
  logic               r_z;
  logic               r_n;
  logic               r_v;
  logic               r_err;

  assign w_op     = opcode_e'(opcode);
  assign in_ready = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
  assign w_accept = in_valid & in_ready;

`ifdef ALU_MUL_EN
  logic w_mul_start;

  assign w_mul_path  = (w_op == OP_MUL);
  assign w_mul_start = w_accept & w_mul_path;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       (operand1),
    .i_b       (operand2),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );
`else
  assign w_mul_path = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_product  = '0;
`endif

  // Single-cycle ops (and MUL without the multiplier) load on acceptance; MUL loads on its last step.
  assign w_load  = (w_accept & ~w_mul_path) | ((r_state == ST_MUL) & w_mul_done);
  assign w_n_nxt = (r_state == ST_MUL) ? w_res_nxt[2*WIDTH-1] : w_res_nxt[WIDTH-1];

  // Next-state decode, including back-to-back acceptance from DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = w_mul_path ? ST_MUL : ST_DONE;
        else          w_state_nxt = ST_IDLE;
      end
      ST_MUL: begin
        if (w_mul_done) w_state_nxt = ST_DONE;
        else            w_state_nxt = ST_MUL;
      end
      ST_DONE: begin
        if (w_accept)       w_state_nxt = w_mul_path ? ST_MUL : ST_DONE;
        else if (out_ready) w_state_nxt = ST_IDLE;
        else                w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result and carry/overflow for whatever is about to be loaded.
  always_comb begin
    w_sum     = '0;
    w_res_nxt = '0;
    w_c_nxt   = 1'b0;
    w_v_nxt   = 1'b0;
    w_err_nxt = 1'b0;
    if (r_state == ST_MUL) begin
      w_res_nxt = w_product;
    end else begin
      case (w_op)
        OP_ADD: begin
          w_sum     = {1'b0, operand1} + {1'b0, operand2};
          w_res_nxt = {{(WIDTH-1){1'b0}}, w_sum};
          w_c_nxt   = w_sum[WIDTH];
          w_v_nxt   = add_ovf(operand1[WIDTH-1], operand2[WIDTH-1], w_sum[WIDTH-1]);
        end
        OP_SUB: begin
          w_sum     = {1'b0, operand1} - {1'b0, operand2};
          w_res_nxt = {{(WIDTH-1){1'b0}}, w_sum};
          w_c_nxt   = w_sum[WIDTH];
          w_v_nxt   = add_ovf(operand1[WIDTH-1], ~operand2[WIDTH-1], w_sum[WIDTH-1]);
        end
`ifdef ALU_MUL_EN
        OP_MUL:  w_res_nxt = '0;
`else
        OP_MUL:  w_err_nxt = 1'b1;
`endif
        OP_AND:  w_res_nxt = {{WIDTH{1'b0}}, operand1 & operand2};
        OP_OR:   w_res_nxt = {{WIDTH{1'b0}}, operand1 | operand2};
        OP_NAND: w_res_nxt = {{WIDTH{1'b0}}, ~(operand1 & operand2)};
        OP_NOR:  w_res_nxt = {{WIDTH{1'b0}}, ~(operand1 | operand2)};
        OP_XOR:  w_res_nxt = {{WIDTH{1'b0}}, operand1 ^ operand2};
        default: w_res_nxt = '0;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Result and flag registers, held until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_load) begin
      r_result <= w_res_nxt;
      r_c      <= w_c_nxt;
      r_z      <= (w_res_nxt == '0);
      r_n      <= w_n_nxt;
      r_v      <= w_v_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign flag_c    = r_c;
  assign flag_z    = r_z;
  assign flag_n    = r_n;
  assign flag_v    = r_v;
  assign op_err    = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8; expectations follow ALU_MUL_EN when it is defined.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic [4:0]     flg;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     opcode;
  logic [W-1:0]   operand1;
  logic [W-1:0]   operand2;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           flag_c;
  logic           flag_z;
  logic           flag_n;
  logic           flag_v;
  logic           op_err;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v),
    .op_err    (op_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: integer arithmetic, flags packed as {c, z, n, v, err}.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t           e;
    int             sa, sb2, s;
    logic [W-1:0]   t;
    logic [2*W-1:0] r;
    logic           c, v, er;
    sa = int'($signed(a));
    sb2 = int'($signed(b));
    c = 1'b0; v = 1'b0; er = 1'b0; r = '0; t = '0; s = 0;
    case (op)
      3'd0: begin
        s = int'(a) + int'(b);
        r = 16'(s);
        c = (s > 255);
        v = ((sa + sb2) > 127) || ((sa + sb2) < -128);
      end
      3'd1: begin
        s = int'(a) - int'(b);
        r = 16'(s & 32'h1FF);
        c = (a < b);
        v = ((sa - sb2) > 127) || ((sa - sb2) < -128);
      end
      3'd2: begin
`ifdef ALU_MUL_EN
        r = 16'(int'(a) * int'(b));
`else
        er = 1'b1;
`endif
      end
      3'd3: begin t = a & b;    r = {{W{1'b0}}, t}; end
      3'd4: begin t = a | b;    r = {{W{1'b0}}, t}; end
      3'd5: begin t = ~(a & b); r = {{W{1'b0}}, t}; end
      3'd6: begin t = ~(a | b); r = {{W{1'b0}}, t}; end
      default: begin t = a ^ b; r = {{W{1'b0}}, t}; end
    endcase
    e.res = r;
    e.flg = {c, (r == '0), (op == 3'd2) ? r[2*W-1] : r[W-1], v, er};
    return e;
  endfunction

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int waited;
    opcode   = op;
    operand1 = a;
    operand2 = b;
    in_valid = 1'b1;
    sb.push_back(model(op, a, b));
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 40) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      waited++;
      @(negedge clk);
    end
    if (waited >= 40) check_eq("accept_timeout", 32'(waited), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: every completed handshake is checked against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq("result", 32'(result), 32'(e.res));
        check_eq("flags", {27'd0, flag_c, flag_z, flag_n, flag_v, op_err}, {27'd0, e.flg});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int             lat;
    int             t0;
    logic [2*W-1:0] hold_exp;
    rst_n = 1'b0; in_valid = 1'b0; opcode = 3'd0;
    operand1 = '0; operand2 = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_flags", {27'd0, flag_c, flag_z, flag_n, flag_v, op_err}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    send(OP_ADD, 8'd200, 8'd100);
    check_eq("lat_add", 32'(out_valid), 32'd1);
    send(OP_SUB,  8'd5,    8'd7);
    send(OP_SUB,  8'd7,    8'd7);
    send(OP_ADD,  8'd127,  8'd1);
    send(OP_NAND, 8'hFF,   8'hFF);
    send(OP_AND,  8'hF0,   8'h3C);
    send(OP_OR,   8'h81,   8'h42);
    send(OP_NOR,  8'h00,   8'h00);
    send(OP_XOR,  8'h5A,   8'hFF);
    send(OP_ADD,  8'hFF,   8'hFF);
    send(OP_SUB,  8'h00,   8'hFF);
    send(OP_SUB,  8'h80,   8'h01);

    send(OP_MUL, 8'hFF, 8'hFF);
    lat = 1;
    while (!out_valid && lat < 40) begin
      check_eq("in_ready_mul", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
`ifdef ALU_MUL_EN
    check_eq("lat_mul", 32'(lat), 32'(W + 1));
`else
    check_eq("lat_mul", 32'(lat), 32'd1);
`endif

    drain();
    out_ready = 1'b0;
    send(OP_XOR, 8'hA5, 8'h0F);
    hold_exp = 16'h00AA;
    repeat (5) begin
      @(negedge clk);
      check_eq("hold_result", 32'(result), 32'(hold_exp));
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      check_eq("hold_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;

    t0 = cyc;
    for (int i = 0; i < 4; i++) send(OP_ADD, 8'(i * 40), 8'(i + 1));
    check_eq("b2b_cycles", 32'(cyc - t0), 32'd4);

    drain();
    send(OP_ADD, 8'd1, 8'd1);
    drain();
`ifdef ALU_MUL_EN
    send(OP_MUL, 8'd13, 8'd11);
    repeat (3) @(posedge clk);
    #1;
`else
    out_ready = 1'b0;
    send(OP_MUL, 8'd13, 8'd11);
    check_eq("op_err_mul", 32'(op_err), 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_result", 32'(result), 32'd0);
    check_eq("abort_op_err", 32'(op_err), 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    for (int i = 0; i < 30; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
